// File: rtl/kalman_pkg.sv
// Shared Q2.14 constants, default sample width and FSM state encoding
// for the tilt front end and the Kalman core.
package kalman_pkg;

  localparam int unsigned Q_FRAC    = 14;
  localparam logic [15:0] Q_ONE     = 16'd16384;
  localparam int unsigned W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/window_accumulator.sv
// Signed sample accumulator producing the rounded window mean. The mean
// includes the sample presented this cycle, so it is valid on the closing sample.
module window_accumulator #(
  parameter int unsigned W      = 16,
  parameter int unsigned N_LOG2 = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         add_i,
  input  logic         clr_i,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] mean_c
);

  localparam int unsigned AW = W + N_LOG2 + 1;
  localparam logic signed [AW-1:0] RND = AW'(2 ** (N_LOG2 - 1));

  logic signed [AW-1:0] sum_q;
  logic signed [AW-1:0] ext_c;
  logic signed [AW-1:0] sum_nxt_c;

  assign ext_c     = {{(AW - W){sample_i[W-1]}}, sample_i};
  assign sum_nxt_c = sum_q + ext_c;

  // Round half toward +inf, then arithmetic divide by the window length
  assign mean_c = W'((sum_nxt_c + RND) >>> N_LOG2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= clr_i ? '0 : sum_nxt_c;
    end
  end

endmodule

// File: rtl/imu_window_averager.sv
// Decimates theta/phi by averaging fixed windows, hands each mean to the
// Kalman core with a start pulse and holds it until the core finishes.
module imu_window_averager
  import kalman_pkg::*;
#(
  parameter int unsigned W      = W_DEFAULT,
  parameter int unsigned N_LOG2 = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] theta_in,
  input  logic [W-1:0] phi_in,
  output logic [W-1:0] theta_acc,
  output logic [W-1:0] phi_acc,
  output logic         kf_start,
  input  logic         kf_finish,
  output logic         busy,
  output logic [7:0]   overrun_cnt
);

  localparam logic [N_LOG2-1:0] IDX_LAST = '1;

  state_e            state_q, state_d;
  logic [N_LOG2-1:0] idx_q;
  logic [W-1:0]      theta_q, theta_d;
  logic [W-1:0]      phi_q, phi_d;
  logic              kf_start_q, kf_start_d;
  logic              busy_q, busy_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              win_done_c;
  logic              latch_c;
  logic              ovr_inc_c;
  logic [W-1:0]      theta_mean_c;
  logic [W-1:0]      phi_mean_c;

  assign win_done_c = sample_valid && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else if (sample_valid) begin
      idx_q <= idx_q + N_LOG2'(1);
    end
  end

  window_accumulator #(.W(W), .N_LOG2(N_LOG2)) u_theta_acc (
    .clk      (clk),
    .reset    (reset),
    .add_i    (sample_valid),
    .clr_i    (win_done_c),
    .sample_i (theta_in),
    .mean_c   (theta_mean_c)
  );

  window_accumulator #(.W(W), .N_LOG2(N_LOG2)) u_phi_acc (
    .clk      (clk),
    .reset    (reset),
    .add_i    (sample_valid),
    .clr_i    (win_done_c),
    .sample_i (phi_in),
    .mean_c   (phi_mean_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      theta_q    <= '0;
      phi_q      <= '0;
      kf_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      theta_q    <= theta_d;
      phi_q      <= phi_d;
      kf_start_q <= kf_start_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  // A window closing while a run is outstanding is dropped, unless the run ends on that same cycle
  always_comb begin
    state_d   = state_q;
    theta_d   = theta_q;
    phi_d     = phi_q;
    ovr_d     = ovr_q;
    latch_c   = 1'b0;
    ovr_inc_c = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (win_done_c) begin
          latch_c = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT;
        ovr_inc_c = win_done_c;
      end
      ST_WAIT: begin
        if (kf_finish && win_done_c) begin
          latch_c = 1'b1;
          state_d = ST_ISSUE;
        end else if (kf_finish) begin
          state_d = ST_ACCUM;
        end else if (win_done_c) begin
          ovr_inc_c = 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    if (latch_c) begin
      theta_d = theta_mean_c;
      phi_d   = phi_mean_c;
    end
    if (ovr_inc_c && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    kf_start_d = (state_d == ST_ISSUE);
    busy_d     = (state_d != ST_ACCUM);
  end

  assign theta_acc   = theta_q;
  assign phi_acc     = phi_q;
  assign kf_start    = kf_start_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_imu_window_averager.sv
// Self-checking bench for imu_window_averager: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_imu_window_averager;

  localparam int W   = 16;
  localparam int NL  = 3;
  localparam int WIN = 8;

  logic         clk;
  logic         reset;
  logic         sample_valid;
  logic [W-1:0] theta_in;
  logic [W-1:0] phi_in;
  logic [W-1:0] theta_acc;
  logic [W-1:0] phi_acc;
  logic         kf_start;
  logic         kf_finish;
  logic         busy;
  logic [7:0]   overrun_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  imu_window_averager #(.W(W), .N_LOG2(NL)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .theta_in     (theta_in),
    .phi_in       (phi_in),
    .theta_acc    (theta_acc),
    .phi_acc      (phi_acc),
    .kf_start     (kf_start),
    .kf_finish    (kf_finish),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: window sums, floor-rounded means, run bookkeeping
  int m_sum_t, m_sum_p, m_cnt;
  int m_theta, m_phi, m_ovr;
  bit m_start, m_busy;

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a % b;
    if (r < 0) r = r + b;
    return (a - r) / b;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit done, can_take, was_start, was_busy;
    int mt, mp;
    if (reset) begin
      m_sum_t = 0; m_sum_p = 0; m_cnt = 0;
      m_theta = 0; m_phi = 0; m_ovr = 0;
      m_start = 0; m_busy = 0;
    end else begin
      done = sample_valid && (m_cnt == WIN - 1);
      mt = 0; mp = 0;
      if (sample_valid) begin
        m_sum_t = m_sum_t + int'($signed(theta_in));
        m_sum_p = m_sum_p + int'($signed(phi_in));
        m_cnt   = m_cnt + 1;
      end
      if (done) begin
        mt = floor_div(m_sum_t + WIN / 2, WIN);
        mp = floor_div(m_sum_p + WIN / 2, WIN);
        m_sum_t = 0; m_sum_p = 0; m_cnt = 0;
      end
      was_start = m_start;
      was_busy  = m_busy;
      // The core may take a new window when idle, or when it is finishing right now (not in the start cycle)
      can_take = !was_busy || (!was_start && kf_finish);
      m_start = 0;
      if (done && can_take) begin
        m_theta = mt; m_phi = mp;
        m_start = 1; m_busy = 1;
      end else begin
        if (done && was_busy && m_ovr < 255) m_ovr = m_ovr + 1;
        if (was_busy && !was_start && kf_finish) m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_chk = n_chk + 5;
      if (theta_acc !== 16'(m_theta)) begin
        n_fail++; $display("FAIL model theta_acc: got %0d expected %0d", $signed(theta_acc), m_theta);
      end
      if (phi_acc !== 16'(m_phi)) begin
        n_fail++; $display("FAIL model phi_acc: got %0d expected %0d", $signed(phi_acc), m_phi);
      end
      if (kf_start !== m_start) begin
        n_fail++; $display("FAIL model kf_start: got %0b expected %0b", kf_start, m_start);
      end
      if (busy !== m_busy) begin
        n_fail++; $display("FAIL model busy: got %0b expected %0b", busy, m_busy);
      end
      if (overrun_cnt !== 8'(m_ovr)) begin
        n_fail++; $display("FAIL model overrun_cnt: got %0d expected %0d", overrun_cnt, m_ovr);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] t, input logic [W-1:0] p, input logic f);
    sample_valid = v; theta_in = t; phi_in = p; kf_finish = f;
    @(posedge clk); #2;
    sample_valid = 1'b0; kf_finish = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic window(input logic [W-1:0] t, input logic [W-1:0] p, input logic fin_last);
    for (int i = 0; i < WIN; i++) step(1'b1, t, p, (i == WIN - 1) ? fin_last : 1'b0);
  endtask

  task automatic finish_run();
    idle();
    step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; theta_in = '0; phi_in = '0; kf_finish = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    chk("reset theta_acc", int'($signed(theta_acc)), 0);
    chk("reset phi_acc", int'($signed(phi_acc)), 0);
    chk("reset kf_start", int'(kf_start), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun_cnt", int'(overrun_cnt), 0);

    window(16'd100, 16'(-200), 1'b0);
    chk("const theta", int'($signed(theta_acc)), 100);
    chk("const phi", int'($signed(phi_acc)), -200);
    chk("const kf_start", int'(kf_start), 1);
    chk("const busy", int'(busy), 1);
    idle();
    chk("start one cycle", int'(kf_start), 0);
    step(1'b0, '0, '0, 1'b1);
    chk("finish clears busy", int'(busy), 0);

    for (int i = 0; i < WIN; i++) step(1'b1, 16'(i), 16'(-3), 1'b0);
    chk("ramp mean", int'($signed(theta_acc)), 4);
    chk("neg mean", int'($signed(phi_acc)), -3);
    finish_run();

    window(16'h7FFF, 16'h8000, 1'b0);
    chk("max mean", int'($signed(theta_acc)), 32767);
    chk("min mean", int'($signed(phi_acc)), -32768);
    finish_run();

    window(16'd1000, 16'(-1000), 1'b0);
    idle();
    window(16'd5, 16'd5, 1'b0);
    window(16'd6, 16'd6, 1'b0);
    chk("overrun two", int'(overrun_cnt), 2);
    chk("held theta", int'($signed(theta_acc)), 1000);
    chk("held phi", int'($signed(phi_acc)), -1000);
    chk("held busy", int'(busy), 1);
    step(1'b0, '0, '0, 1'b1);
    chk("back to idle", int'(busy), 0);
    window(16'd7, 16'd8, 1'b0);
    chk("reissue start", int'(kf_start), 1);
    chk("reissue theta", int'($signed(theta_acc)), 7);
    idle();

    window(16'd9, 16'(-9), 1'b1);
    chk("coincident start", int'(kf_start), 1);
    chk("coincident theta", int'($signed(theta_acc)), 9);
    chk("coincident overrun", int'(overrun_cnt), 2);
    idle();

    for (int w = 0; w < 300; w++) window(16'd11, 16'd12, 1'b0);
    chk("overrun saturate", int'(overrun_cnt), 255);
    chk("saturate held theta", int'($signed(theta_acc)), 9);

    for (int i = 0; i < 5; i++) step(1'b1, 16'd50, 16'd60, 1'b0);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("mid reset theta", int'($signed(theta_acc)), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset overrun", int'(overrun_cnt), 0);
    for (int i = 0; i < WIN - 1; i++) step(1'b1, 16'd40, 16'd20, 1'b0);
    chk("no early start", int'(kf_start), 0);
    chk("no early theta", int'($signed(theta_acc)), 0);
    step(1'b1, 16'd40, 16'd20, 1'b0);
    chk("fresh window start", int'(kf_start), 1);
    chk("fresh window theta", int'($signed(theta_acc)), 40);
    finish_run();

    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 6) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imu_window_averager.md
# imu_window_averager

Front-end stage feeding `kalman_fsm`. Decimates the raw tilt-angle stream (theta/phi, signed Q2.14) by averaging fixed windows of 2^N_LOG2 samples. It presents the rounded means on `theta_acc`/`phi_acc` and issues a one-cycle `kf_start`. It then holds those outputs stable until the filter signals `kf_finish`, because the filter re-reads its measurement inputs late in its iteration. Windows that complete while the filter is still busy are dropped and counted.

## Interface
- `W`, 16: sample and output width, signed Q2.14.
- `N_LOG2`, 3: log2 of window length; legal range 1..6.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `sample_valid`  in  1  `theta_in`/`phi_in` valid this cycle.
- `theta_in`  in  W  signed raw theta sample.
- `phi_in`  in  W  signed raw phi sample.
- `theta_acc`  out  W  signed windowed theta mean, held during a filter run.
- `phi_acc`  out  W  signed windowed phi mean, held during a filter run.
- `kf_start`  out  1  one-cycle start pulse to the Kalman core.
- `kf_finish`  in  1  one-cycle done pulse from the Kalman core.
- `busy`  out  1  high while a filter run is outstanding.
- `overrun_cnt`  out  8  saturating count of dropped windows.

## Operation
- Accumulation runs in every state.
  - Each `sample_valid` adds sign-extended `theta_in`/`phi_in` to accumulators of width W+N_LOG2+1 and increments `sample_idx` (N_LOG2 bits).
  - Cycles without `sample_valid` change nothing.
- Window completes on the valid sample with `sample_idx == 2^N_LOG2-1`.
  - Mean = (sum + 2^(N_LOG2-1)) >>> N_LOG2, arithmetic shift, i.e. round half toward +inf.
  - The result always fits in W bits; no saturation is needed.
  - Accumulators and `sample_idx` clear on the same edge, so the next window starts with the following sample.
- FSM states:
  - ACCUM: no run outstanding.
    - On window completion: latch means into `theta_acc`/`phi_acc`, go to ISSUE.
  - ISSUE: `kf_start`=1 for exactly this cycle; go to WAIT.
  - WAIT: `busy`=1; outputs frozen.
    - On `kf_finish`: go to ACCUM.
    - On window completion without `kf_finish`: discard means, `overrun_cnt` += 1, saturating at 255.
    - On window completion and `kf_finish` in the same cycle: latch the new means, go to ISSUE; no overrun.
- Window completion in ISSUE counts as an overrun.
- `kf_finish` arriving in ACCUM or ISSUE is ignored.
- `busy` = 1 in ISSUE and WAIT.

## Timing
- Reset values: `theta_acc`=0, `phi_acc`=0, `kf_start`=0, `busy`=0, `overrun_cnt`=0. State ACCUM, accumulators 0, `sample_idx` 0.
- Reset mid-window or mid-run discards everything; the first post-reset window begins with the first valid sample after reset deasserts.
- Window completion at edge k: `theta_acc`/`phi_acc` update at edge k and `kf_start` is high during cycle k→k+1.
  - The means are stable for at least one cycle before the filter samples them in its INITIAL state.
- All outputs are registered; no combinational input-to-output paths.
- Sustained throughput: one window per filter iteration. Minimum start-to-start spacing is 2 cycles after a `kf_finish`.

## Structure
- `kalman_pkg`:
  - Q2.14 constants (`Q_FRAC=14`, `Q_ONE=16'd16384`).
  - Default `W`.
  - FSM state encoding, shared with the `kalman_fsm` state localparams for waveform consistency.
- Sub-module `window_accumulator` (`W`, `N_LOG2`), instanced twice (theta, phi).
  - Signed accumulate, clear, and rounded-mean output.
  - `sample_idx` and the FSM stay in the top level.

## Test plan
- N_LOG2=3, 8 valid samples theta=100, phi=-200 → `theta_acc`=100, `phi_acc`=-200, `kf_start` pulses 1 cycle at the 8th sample's edge, `busy`=1.
- Theta samples 0..7 → mean 4 (28+4 >>> 3). All -3 → -3. All 32767 → 32767. All -32768 → -32768.
- `kf_finish` withheld across 2 further full windows → `overrun_cnt`=2, outputs stay at the first window's values; `kf_finish` then returns the FSM to ACCUM, and the next window issues normally.
- `kf_finish` coincident with a window's last sample → immediate new `kf_start` next cycle, `overrun_cnt` unchanged.
- 300 consecutive overrun windows → `overrun_cnt` saturates at 255.
- `reset` asserted after 5 samples of a window, released → `sample_idx` restarts; `kf_start` fires only after 8 fresh valid samples; all outputs read 0 until then.
